// File: rtl/cmv300_if.sv
// Sensor-side pixel port of the CMV300 frame emulator.
// master: the emulator (takes request/pattern controls, drives pixel bus and status).
// slave : the consumer or test harness (drives request/pattern controls, observes outputs).
interface cmv300_if;
    localparam int unsigned PIX_W = 10;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 16;

    logic             CVM300_FRAME_REQ;
    logic [SEL_W-1:0] pattern_sel;
    logic [PIX_W-1:0] const_value;
    logic [PIX_W-1:0] CVM300_D;
    logic             CVM300_Data_valid;
    logic             busy;
    logic             frame_done;
    logic [CNT_W-1:0] frame_count;

    modport master (
        input  CVM300_FRAME_REQ,
        input  pattern_sel,
        input  const_value,
        output CVM300_D,
        output CVM300_Data_valid,
        output busy,
        output frame_done,
        output frame_count
    );

    modport slave (
        output CVM300_FRAME_REQ,
        output pattern_sel,
        output const_value,
        input  CVM300_D,
        input  CVM300_Data_valid,
        input  busy,
        input  frame_done,
        input  frame_count
    );
endinterface

// File: rtl/cmv300_frame_emulator.sv
// CMV300 sensor output stand-in: answers a rising frame request with a full
// frame of 10-bit test-pattern pixels qualified by a data-valid strobe.
// Ports:
//   FSM_Clk    - sole clock, rising edge
//   SYS_RES_N  - synchronous active-low reset
//   bus        - cmv300_if.master: request/pattern controls in; pixel data,
//                valid, busy, frame_done and frame_count out (all registered)
module cmv300_frame_emulator #(
    parameter int unsigned ROWS       = 488,
    parameter int unsigned COLS       = 648,
    parameter int unsigned FOT_CYCLES = 16,
    parameter int unsigned LINE_GAP   = 8
) (
    input  logic     FSM_Clk,
    input  logic     SYS_RES_N,
    cmv300_if.master bus
);
    localparam int unsigned PIX_W = 10;
    localparam int unsigned POS_W = 10;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned DLY_W = 16;
    localparam int unsigned CNT_W = 16;

    localparam logic [POS_W-1:0] LAST_COL = POS_W'(COLS - 1);
    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(ROWS - 1);
    localparam logic [DLY_W-1:0] FOT_LAST = DLY_W'(FOT_CYCLES - 1);
    localparam logic [DLY_W-1:0] GAP_LAST = DLY_W'(LINE_GAP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOT  = 2'd1,
        LINE = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             req_d;
    logic             armed;
    logic [DLY_W-1:0] dly_cnt;
    logic [DLY_W-1:0] dly_cnt_nx;
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] row_nx;
    logic [POS_W-1:0] col;
    logic [POS_W-1:0] col_nx;
    logic [PIX_W-1:0] ramp;
    logic [PIX_W-1:0] ramp_nx;
    logic [SEL_W-1:0] pat_q;
    logic [SEL_W-1:0] pat_nx;
    logic [PIX_W-1:0] cval_q;
    logic [PIX_W-1:0] cval_nx;

    logic             accept_c;
    logic             last_pix_c;
    logic [PIX_W-1:0] pix_c;

    logic             last_pix_q;
    logic [PIX_W-1:0] d_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] count_q;

    // State register plus frame counters and latched pattern controls.
    always_ff @(posedge FSM_Clk) begin
        if (!SYS_RES_N) begin
            state   <= IDLE;
            req_d   <= 1'b0;
            armed   <= 1'b0;
            dly_cnt <= '0;
            row     <= '0;
            col     <= '0;
            ramp    <= '0;
            pat_q   <= '0;
            cval_q  <= '0;
        end else begin
            state   <= state_nx;
            req_d   <= bus.CVM300_FRAME_REQ;
            // A request level already high when reset releases is not an edge;
            // it must be seen low once before any request can be accepted.
            armed   <= armed | ~bus.CVM300_FRAME_REQ;
            dly_cnt <= dly_cnt_nx;
            row     <= row_nx;
            col     <= col_nx;
            ramp    <= ramp_nx;
            pat_q   <= pat_nx;
            cval_q  <= cval_nx;
        end
    end

    // Next-state, counter updates and pixel selection.
    always_comb begin
        state_nx   = state;
        dly_cnt_nx = dly_cnt;
        row_nx     = row;
        col_nx     = col;
        ramp_nx    = ramp;
        pat_nx     = pat_q;
        cval_nx    = cval_q;
        accept_c   = 1'b0;
        last_pix_c = 1'b0;

        case (state)
            IDLE: begin
                if (bus.CVM300_FRAME_REQ && !req_d && armed) begin
                    accept_c   = 1'b1;
                    pat_nx     = bus.pattern_sel;
                    cval_nx    = bus.const_value;
                    row_nx     = '0;
                    col_nx     = '0;
                    ramp_nx    = '0;
                    dly_cnt_nx = '0;
                    state_nx   = (FOT_CYCLES == 0) ? LINE : FOT;
                end
            end
            FOT: begin
                if (dly_cnt == FOT_LAST) begin
                    dly_cnt_nx = '0;
                    state_nx   = LINE;
                end else begin
                    dly_cnt_nx = dly_cnt + DLY_W'(1);
                end
            end
            LINE: begin
                ramp_nx = ramp + PIX_W'(1);
                if (col == LAST_COL) begin
                    col_nx = '0;
                    if (row == LAST_ROW) begin
                        last_pix_c = 1'b1;
                        state_nx   = IDLE;
                    end else begin
                        row_nx     = row + POS_W'(1);
                        dly_cnt_nx = '0;
                        state_nx   = (LINE_GAP == 0) ? LINE : GAP;
                    end
                end else begin
                    col_nx = col + POS_W'(1);
                end
            end
            GAP: begin
                if (dly_cnt == GAP_LAST) begin
                    dly_cnt_nx = '0;
                    state_nx   = LINE;
                end else begin
                    dly_cnt_nx = dly_cnt + DLY_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        case (pat_q)
            2'd0:    pix_c = ramp;
            2'd1:    pix_c = PIX_W'(row);
            2'd2:    pix_c = PIX_W'(col);
            default: pix_c = cval_q;
        endcase
    end

    // Registered outputs; data/valid trail the LINE state by one cycle,
    // and frame_done trails the last valid pixel by one more.
    always_ff @(posedge FSM_Clk) begin
        if (!SYS_RES_N) begin
            d_q        <= '0;
            valid_q    <= 1'b0;
            last_pix_q <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            d_q        <= (state == LINE) ? pix_c : '0;
            valid_q    <= (state == LINE);
            last_pix_q <= last_pix_c;
            done_q     <= last_pix_q;
            if (last_pix_q) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (accept_c) begin
                busy_q <= 1'b1;
            end else if (last_pix_q) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.CVM300_D          = d_q;
    assign bus.CVM300_Data_valid = valid_q;
    assign bus.busy              = busy_q;
    assign bus.frame_done        = done_q;
    assign bus.frame_count       = count_q;

endmodule

// File: tb/tb_cmv300_frame_emulator.sv
// Self-checking bench for cmv300_frame_emulator: three parameterisations
// (basic 4x8, zero-delay 4x8, wrap 2x1023) checked cycle by cycle against a
// frame-timing model, plus a vector table and hand-written corner sequences.
module tb_cmv300_frame_emulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a [3];
    logic [1:0] pat_a [3];
    logic [9:0] cv_a  [3];
    int         sel;

    logic       o_v;
    logic [9:0] o_d;
    logic       o_busy;
    logic       o_done;
    logic [15:0] o_cnt;

    logic [15:0] exp_cnt [3];
    int          n_vec;
    int          n_bad;

    always #5 clk = ~clk;

    cmv300_if if0 ();
    cmv300_if if1 ();
    cmv300_if if2 ();

    assign if0.CVM300_FRAME_REQ = req_a[0];
    assign if0.pattern_sel      = pat_a[0];
    assign if0.const_value      = cv_a[0];
    assign if1.CVM300_FRAME_REQ = req_a[1];
    assign if1.pattern_sel      = pat_a[1];
    assign if1.const_value      = cv_a[1];
    assign if2.CVM300_FRAME_REQ = req_a[2];
    assign if2.pattern_sel      = pat_a[2];
    assign if2.const_value      = cv_a[2];

    cmv300_frame_emulator #(.ROWS(4), .COLS(8), .FOT_CYCLES(3), .LINE_GAP(2)) u0 (
        .FSM_Clk(clk), .SYS_RES_N(rst_n), .bus(if0.master));
    cmv300_frame_emulator #(.ROWS(4), .COLS(8), .FOT_CYCLES(0), .LINE_GAP(0)) u1 (
        .FSM_Clk(clk), .SYS_RES_N(rst_n), .bus(if1.master));
    cmv300_frame_emulator #(.ROWS(2), .COLS(1023), .FOT_CYCLES(16), .LINE_GAP(5)) u2 (
        .FSM_Clk(clk), .SYS_RES_N(rst_n), .bus(if2.master));

    always_comb begin
        case (sel)
            1: begin
                o_v = if1.CVM300_Data_valid; o_d = if1.CVM300_D; o_busy = if1.busy;
                o_done = if1.frame_done; o_cnt = if1.frame_count;
            end
            2: begin
                o_v = if2.CVM300_Data_valid; o_d = if2.CVM300_D; o_busy = if2.busy;
                o_done = if2.frame_done; o_cnt = if2.frame_count;
            end
            default: begin
                o_v = if0.CVM300_Data_valid; o_d = if0.CVM300_D; o_busy = if0.busy;
                o_done = if0.frame_done; o_cnt = if0.frame_count;
            end
        endcase
    end

    function automatic int rows_of(input int i);
        return (i == 2) ? 2 : 4;
    endfunction
    function automatic int cols_of(input int i);
        return (i == 2) ? 1023 : 8;
    endfunction
    function automatic int fot_of(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 0 : 16);
    endfunction
    function automatic int gap_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 0 : 5);
    endfunction
    function automatic int frame_len(input int i);
        return rows_of(i) * cols_of(i) + (rows_of(i) - 1) * gap_of(i);
    endfunction
    // Cycle offset (after the accepting edge) at which frame_done shows.
    function automatic int done_at(input int i);
        return fot_of(i) + 1 + frame_len(i);
    endfunction

    // Expected {valid, data, busy, frame_done, frame_count} t cycles after acceptance.
    function automatic logic [28:0] model(input int i, input int t, input int pat,
                                          input logic [9:0] cv, input logic [15:0] base);
        int         s, p, r, c;
        logic       v;
        logic [9:0] d;
        logic [15:0] cnt;
        v = 1'b0;
        d = 10'd0;
        s = t - 1 - fot_of(i);
        if (s >= 0 && s < frame_len(i)) begin
            p = cols_of(i) + gap_of(i);
            r = s / p;
            c = s % p;
            if (c < cols_of(i)) begin
                v = 1'b1;
                case (pat)
                    0:       d = 10'((r * cols_of(i) + c) % 1024);
                    1:       d = 10'(r);
                    2:       d = 10'(c);
                    default: d = cv;
                endcase
            end
        end
        cnt = (t >= done_at(i)) ? base + 16'd1 : base;
        return {v, d, (t < done_at(i)), (t == done_at(i)), cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Runs one frame on instance i: request edge, then per-cycle model check.
    // hold: request high for this many sampled edges; retrig: offset of an extra
    // one-cycle re-pulse (-1 none); pre_armed: request already raised by the
    // previous call; chain: raise the next request in the frame_done cycle.
    task automatic run_frame(input int i, input int pat, input logic [9:0] cv,
                             input int hold, input int retrig, input bit pre_armed,
                             input bit chain, output logic [9:0] first_d,
                             output logic [9:0] last_d);
        int   n;
        int   dt;
        bit   seen;
        logic [28:0] act;
        logic [28:0] exp;
        sel      = i;
        pat_a[i] = 2'(pat);
        cv_a[i]  = cv;
        if (!pre_armed) begin
            req_a[i] = 1'b0;
            @(negedge clk);
            req_a[i] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble live controls: the frame must use the latched values.
        pat_a[i] = 2'($urandom);
        cv_a[i]  = 10'($urandom);
        dt = done_at(i);
        n  = chain ? dt : (((dt > hold + 1) ? dt : hold + 1) + 3);
        seen    = 1'b0;
        first_d = 10'd0;
        last_d  = 10'd0;
        for (int t = 0; t <= n; t++) begin
            act = {o_v, o_d, o_busy, o_done, o_cnt};
            exp = model(i, t, pat, cv, exp_cnt[i]);
            check($sformatf("cyc inst%0d t%0d", i, t), 32'(act), 32'(exp));
            if (o_v) begin
                if (!seen) first_d = o_d;
                seen   = 1'b1;
                last_d = o_d;
            end
            if (chain && t == dt) begin
                req_a[i] = 1'b1;
            end else begin
                req_a[i] = ((t + 1) < hold) || (t == retrig);
            end
            if (t < n) @(negedge clk);
        end
        exp_cnt[i] = exp_cnt[i] + 16'd1;
    endtask

    typedef struct {
        int         inst;
        int         pat;
        logic [9:0] cv;
        int         hold;
        int         retrig;
        logic [9:0] exp_first;
        logic [9:0] exp_last;
        logic [15:0] exp_count;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [9:0] f;
        logic [9:0] l;

        tbl[0] = '{0, 0, 10'h000, 1,   -1, 10'd0,   10'd31,   16'd1};
        tbl[1] = '{0, 1, 10'h3FF, 1,   -1, 10'd0,   10'd3,    16'd2};
        tbl[2] = '{0, 2, 10'h155, 1,   -1, 10'd0,   10'd7,    16'd3};
        tbl[3] = '{0, 3, 10'h2A5, 1,   -1, 10'h2A5, 10'h2A5,  16'd4};
        tbl[4] = '{0, 0, 10'h000, 1,    8, 10'd0,   10'd31,   16'd5};
        tbl[5] = '{0, 0, 10'h000, 100, -1, 10'd0,   10'd31,   16'd6};
        tbl[6] = '{1, 0, 10'h000, 1,   -1, 10'd0,   10'd31,   16'd1};
        tbl[7] = '{1, 1, 10'h0F0, 1,   -1, 10'd0,   10'd3,    16'd2};
        tbl[8] = '{2, 0, 10'h000, 1,   -1, 10'd0,   10'd1021, 16'd1};
        tbl[9] = '{2, 2, 10'h000, 1,   -1, 10'd0,   10'd1022, 16'd2};

        n_vec = 0;
        n_bad = 0;
        sel   = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_a[i]   = 1'b0;
            pat_a[i]   = 2'd0;
            cv_a[i]    = 10'd0;
            exp_cnt[i] = 16'd0;
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            check($sformatf("reset_out inst%0d", i), 32'({o_v, o_d, o_busy, o_done, o_cnt}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        for (int k = 0; k < 10; k++) begin
            run_frame(tbl[k].inst, tbl[k].pat, tbl[k].cv, tbl[k].hold, tbl[k].retrig,
                      1'b0, 1'b0, f, l);
            check($sformatf("first_pix vec%0d", k), 32'(f), 32'(tbl[k].exp_first));
            check($sformatf("last_pix vec%0d", k), 32'(l), 32'(tbl[k].exp_last));
            check($sformatf("count vec%0d", k), 32'(o_cnt), 32'(tbl[k].exp_count));
        end

        // Zero-delay back-to-back: next request raised in the frame_done cycle.
        run_frame(1, 2, 10'd0, 1, -1, 1'b0, 1'b1, f, l);
        check("chain_count1", 32'(o_cnt), 32'd3);
        run_frame(1, 3, 10'h2A5, 1, -1, 1'b1, 1'b0, f, l);
        check("chain_first", 32'(f), 32'h2A5);
        check("chain_count2", 32'(o_cnt), 32'd4);

        // Reset in row 2 with the request held high through release.
        sel      = 0;
        pat_a[0] = 2'd0;
        req_a[0] = 1'b0;
        @(negedge clk);
        req_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repeat (27) @(negedge clk);
        check("pre_reset_pix", 32'({o_v, o_d}), 32'({1'b1, 10'd19}));
        rst_n = 1'b0;
        @(negedge clk);
        check("midframe_reset", 32'({o_v, o_d, o_busy, o_done, o_cnt}), 32'd0);
        sel = 2;
        #1;
        check("reset_count_inst2", 32'(o_cnt), 32'd0);
        sel   = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) exp_cnt[i] = 16'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("held_req_idle c%0d", c), 32'({o_v, o_busy, o_cnt}), 32'd0);
        end
        req_a[0] = 1'b0;
        @(negedge clk);
        run_frame(0, 0, 10'd0, 1, -1, 1'b0, 1'b0, f, l);
        check("post_reset_count", 32'(o_cnt), 32'd1);
        check("post_reset_last", 32'(l), 32'd31);

        // Randomised frames against the model.
        for (int k = 0; k < 8; k++) begin
            int i;
            int rt;
            i  = $urandom_range(0, 2);
            rt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 20)) : -1;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_frame(i, $urandom_range(0, 3), 10'($urandom), $urandom_range(1, 4), rt,
                      1'b0, 1'b0, f, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
